// File: rtl/ram_byte_loader.sv
// Boot loader: header + big-endian byte stream to 32-bit RAM words.
// Optional trailer checksum check when LOADER_CHECKSUM_EN is defined.
module ram_byte_loader #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_dataIn,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDRESS_WIDTH:0]   words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE
  } state_e;
  localparam state_e S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE
  } state_e;
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [15:0]              len_q, len_d;
  logic [31:0]              word_q, word_d;
  logic                     wen_q, wen_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     rdy_q, rdy_d;
  logic [ADDRESS_WIDTH:0]   wl_q, wl_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               xor_q, xor_d;
`endif

  logic        accept;
  logic [15:0] hdr;
  logic [16:0] wl_next;

  assign accept  = byte_valid && rdy_q;
  assign hdr     = {len_q[7:0], byte_in};
  assign wl_next = 17'(wl_q) + 17'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    word_d  = word_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    wl_d    = wl_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          err_d   = 1'b0;
          wl_d    = '0;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d = hdr;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d = '0;
            if (32'(hdr) > DEPTH) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (hdr == 16'd0) begin
              state_d = S_TAIL;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], byte_in};
          cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ byte_in;
`endif
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            wen_d   = 1'b1;
            addr_d  = ADDRESS_WIDTH'(BASE_ADDR)
                    + wl_q[ADDRESS_WIDTH-1:0];
            data_d  = word_d;
          end
        end
      end
      S_WRITE: begin
        wl_d    = wl_next[ADDRESS_WIDTH:0];
        state_d = (wl_next < {1'b0, len_q}) ? S_DATA : S_TAIL;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        // trailer mismatch still completes; err flags it
        if (accept) begin
          state_d = S_DONE;
          err_d   = (byte_in != xor_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    rdy_d  = (state_d == S_LEN) || (state_d == S_DATA)
          || (state_d == S_CHK);
`else
    rdy_d  = (state_d == S_LEN) || (state_d == S_DATA);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wl_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      wl_q    <= wl_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign byte_ready   = rdy_q;
  assign ram_wEn      = wen_q;
  assign ram_addr     = addr_q;
  assign ram_dataIn   = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
